// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the flash command-bus scheduler.
package spi_sched_pkg;

    localparam int SPI_DSIZE = 8;
    localparam int SPI_CMD_W = 4;
    localparam int ADDR_W    = 3 * SPI_DSIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_t;

    localparam logic [SPI_CMD_W-1:0] CMD_READ_MEM     = 4'h1;
    localparam logic [SPI_CMD_W-1:0] CMD_WRITE_PAGE   = 4'h2;
    localparam logic [SPI_CMD_W-1:0] CMD_SECTOR_ERASE = 4'h3;
    localparam logic [SPI_CMD_W-1:0] CMD_READ_STATUS  = 4'h4;
    localparam logic [SPI_CMD_W-1:0] CMD_WRITE_EN     = 4'h5;

endpackage

// File: rtl/spi_cmd_scheduler_rr_arb.sv
// Combinational round-robin pick: first set req at or after (ptr+1) mod NUM_REQ.
module spi_rr_arb
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   winner,
    output logic [NUM_REQ-1:0] onehot
);

    logic [PTR_W-1:0] cand;

    // Scan from farthest to nearest so the nearest set request overwrites last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        cand   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Round-robin scheduler for the shared flash command bus; tracks busy -> finish per grant.
// Optional abort timer and err pulses are enabled by SPI_SCHED_TIMEOUT_EN.
//   state   | meaning
//   S_IDLE  | outputs cleared, arbitrate once command modules are quiet
//   S_ISSUE | cmd_request high, waiting for a module to raise busy
//   S_WAIT  | command accepted, waiting for finish
//   S_DONE  | one-cycle done/err pulse, grant still held
module spi_cmd_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_MOD = 8,
    parameter int CMD_W   = 4,
    parameter int DSIZE   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CMD_W-1:0]     req_cmd,
    input  logic [NUM_REQ*3*DSIZE-1:0]   req_addr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic                         cmd_request,
    output logic [CMD_W-1:0]             cmd_code,
    output logic [3*DSIZE-1:0]           cmd_addr,
    input  logic [NUM_MOD-1:0]           mod_busy,
    input  logic [NUM_MOD-1:0]           mod_finish,
    output logic                         sched_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = 3 * DSIZE;

    sched_state_t       state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_valid;
    logic               guard_ok;
    logic               to_hit;
    logic [CMD_W-1:0]   sel_cmd;
    logic [AW-1:0]      sel_addr;

    spi_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .valid   (win_valid),
        .winner  (win_idx),
        .onehot  (win_onehot)
    );

    // Command modules hold busy while in reset, so never issue until the bus is quiet.
    assign guard_ok = (mod_busy == '0) && (mod_finish == '0);

    always_comb begin
        sel_cmd  = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_cmd  = req_cmd[i*CMD_W +: CMD_W];
                sel_addr = req_addr[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            done        <= '0;
            cmd_request <= 1'b0;
            cmd_code    <= '0;
            cmd_addr    <= '0;
            sched_busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid && guard_ok) begin
                        gnt         <= win_onehot;
                        cmd_request <= 1'b1;
                        cmd_code    <= sel_cmd;
                        cmd_addr    <= sel_addr;
                        ptr         <= win_idx;
                        sched_busy  <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (to_hit) begin
                        cmd_request <= 1'b0;
                        state       <= S_DONE;
                    end else if (|mod_busy) begin
                        cmd_request <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (|mod_finish) begin
                        done  <= gnt;
                        state <= S_DONE;
                    end else if (to_hit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    gnt         <= '0;
                    done        <= '0;
                    cmd_request <= 1'b0;
                    cmd_code    <= '0;
                    cmd_addr    <= '0;
                    sched_busy  <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Fires on the cycle whose edge makes the count reach TIMEOUT, so err lands exactly then.
    assign to_hit = (({16'd0, to_cnt} + 32'd1) == 32'(TIMEOUT)) &&
                    ((state == S_ISSUE) || (state == S_WAIT));

    always_ff @(posedge clock) begin
        if (rst) begin
            to_cnt <= '0;
            err    <= '0;
        end else begin
            to_cnt <= ((state == S_ISSUE) || (state == S_WAIT)) ? to_cnt + 16'd1 : 16'd0;
            err    <= (to_hit && !((state == S_WAIT) && (|mod_finish))) ? gnt : '0;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT;
    assign to_hit = 1'b0;
    assign err    = '0;
`endif

endmodule
